alu_instr_sequencer: RTL

- Upstream control stage for ALU_RegFile.
- Holds a small loadable program memory and fetches and decodes one instruction at a time.
- Drives read_reg1, read_reg2, write_reg, opcode and reg_write into ALU_RegFile, and captures its 8-bit result.
- Start/busy/done handshake to the testbench or host controller.

---
 rtl/alu_instr_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_instr_sequencer.sv
// Fetch/decode sequencer driving ALU_RegFile from a small loadable program memory.
// Optional single-step mode (PAUSE state, step_en/step ports) is enabled by SEQ_SINGLE_STEP_EN.
module alu_instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [7:0]    alu_result,
    output logic [2:0]    read_reg1,
    output logic [2:0]    read_reg2,
    output logic [2:0]    write_reg,
    output logic [1:0]    opcode,
    output logic          reg_write,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [7:0]    last_result,
    output logic [7:0]    instr_count
`ifdef SEQ_SINGLE_STEP_EN
    ,
    input  logic          step_en,
    input  logic          step
`endif
);

`ifdef SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4,
        S_PAUSE = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`endif

    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PC_ONE     = AW'(1);
    localparam logic [1:0]    CLS_ALU_WB = 2'b00;
    localparam logic [1:0]    CLS_NOP    = 2'b10;
    localparam logic [1:0]    CLS_HALT   = 2'b11;

    state_t        state_r;
    logic [IW-1:0] mem_r [0:DEPTH-1];
    logic [1:0]    ir_class_r;
    logic [2:0]    read_reg1_r;
    logic [2:0]    read_reg2_r;
    logic [2:0]    write_reg_r;
    logic [1:0]    opcode_r;
    logic          reg_write_r;
    logic          busy_r;
    logic          done_r;
    logic [AW-1:0] pc_r;
    logic [7:0]    last_result_r;
    logic [7:0]    instr_count_r;

    logic [1:0]    fetch_class_s;
    logic          at_end_s;
    logic          pause_s;
    logic [7:0]    count_next_s;

    assign fetch_class_s = mem_r[pc_r][15:14];
    assign at_end_s      = (pc_r == LAST_ADDR);
    assign count_next_s  = (instr_count_r == 8'hFF) ? 8'hFF : (instr_count_r + 8'd1);
`ifdef SEQ_SINGLE_STEP_EN
    assign pause_s       = step_en;
`else
    assign pause_s       = 1'b0;
`endif

    // Program memory: written only while idle; contents survive rst_n
    always_ff @(posedge clk) begin
        if ((state_r == S_IDLE) && prog_we) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // Sequencer FSM with registered outputs; done and reg_write are single-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            ir_class_r    <= 2'b00;
            read_reg1_r   <= 3'd0;
            read_reg2_r   <= 3'd0;
            write_reg_r   <= 3'd0;
            opcode_r      <= 2'b00;
            reg_write_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pc_r          <= '0;
            last_result_r <= 8'h00;
            instr_count_r <= 8'h00;
        end else begin
            done_r      <= 1'b0;
            reg_write_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        pc_r          <= '0;
                        instr_count_r <= 8'h00;
                        busy_r        <= 1'b1;
                        state_r       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir_class_r <= fetch_class_s;
                    case (fetch_class_s)
                        CLS_NOP: begin
                            if (at_end_s) begin
                                done_r  <= 1'b1;
                                state_r <= S_DONE;
                            end else if (pause_s) begin
`ifdef SEQ_SINGLE_STEP_EN
                                state_r <= S_PAUSE;
`endif
                            end else begin
                                pc_r    <= pc_r + PC_ONE;
                                state_r <= S_FETCH;
                            end
                        end
                        CLS_HALT: begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end
                        default: begin
                            opcode_r    <= mem_r[pc_r][13:12];
                            write_reg_r <= mem_r[pc_r][11:9];
                            read_reg1_r <= mem_r[pc_r][8:6];
                            read_reg2_r <= mem_r[pc_r][5:3];
                            state_r     <= S_EXEC;
                        end
                    endcase
                end
                S_EXEC: begin
                    last_result_r <= alu_result;
                    instr_count_r <= count_next_s;
                    reg_write_r   <= (ir_class_r == CLS_ALU_WB);
                    state_r       <= S_WB;
                end
                S_WB: begin
                    if (at_end_s) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else if (pause_s) begin
`ifdef SEQ_SINGLE_STEP_EN
                        state_r <= S_PAUSE;
`endif
                    end else begin
                        pc_r    <= pc_r + PC_ONE;
                        state_r <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
`ifdef SEQ_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        pc_r    <= pc_r + PC_ONE;
                        state_r <= S_FETCH;
                    end
                end
`endif
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign read_reg1   = read_reg1_r;
    assign read_reg2   = read_reg2_r;
    assign write_reg   = write_reg_r;
    assign opcode      = opcode_r;
    assign reg_write   = reg_write_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pc          = pc_r;
    assign last_result = last_result_r;
    assign instr_count = instr_count_r;

endmodule
